// File: rtl/sgd_loss_engine.sv
// sgd_loss_engine
//
// Purpose:
//   Per-bank SGD gradient/loss engine. Label vectors (b) are queued in a
//   first-word-fall-through FIFO. Each incoming dot-product vector (ax) pops
//   one label vector and flows through a three-stage pipeline:
//     S1 capture : dot, label and registered config are latched together
//     S2 loss    : linear (ax - b, saturated) or hinge loss per bank
//     S3 shift   : arithmetic right shift (step size), optional round-half-up
//   A dot that arrives while the FIFO is empty is still processed, with b = 0,
//   and raises the sticky err_underflow flag.
//
// Ports:
//   clk, rst          : rising-edge clock, synchronous active-high reset
//   cfg_shift         : right-shift amount applied in S3
//   cfg_mode          : 0 = linear loss, 1 = hinge loss
//   cfg_round         : 1 = round-half-up on the shift
//   b_data/b_valid    : label vector push; accepted when b_valid && b_ready
//   b_ready           : FIFO has room (low during reset)
//   dot_data/dot_valid: dot-product vector, no backpressure
//   loss_data         : scaled gradient per bank
//   loss_valid        : single valid for all banks of loss_data
//   b_count           : FIFO occupancy
//   err_clr           : clears the sticky error flags (a same-cycle set wins)
//   err_underflow     : sticky, dot arrived while FIFO empty
//   err_sat           : sticky, a linear-mode result was clamped

module sgd_loss_engine #(
    parameter int              NUM_BANKS       = 8,
    parameter int              DW              = 32,
    parameter int              FIFO_DEPTH_BITS = 6,
    parameter logic [DW-1:0]   HINGE_ONE       = 32'h0001_0000
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [4:0]                   cfg_shift,
    input  logic                         cfg_mode,
    input  logic                         cfg_round,
    input  logic [DW*NUM_BANKS-1:0]      b_data,
    input  logic                         b_valid,
    output logic                         b_ready,
    input  logic [DW*NUM_BANKS-1:0]      dot_data,
    input  logic                         dot_valid,
    output logic [DW*NUM_BANKS-1:0]      loss_data,
    output logic                         loss_valid,
    output logic [FIFO_DEPTH_BITS:0]     b_count,
    input  logic                         err_clr,
    output logic                         err_underflow,
    output logic                         err_sat
);

    localparam int VW    = DW * NUM_BANKS;
    localparam int DEPTH = 2 ** FIFO_DEPTH_BITS;
    localparam logic [FIFO_DEPTH_BITS:0] FULL_COUNT = {1'b1, {FIFO_DEPTH_BITS{1'b0}}};
    localparam logic signed [DW-1:0] HINGE_POS = HINGE_ONE;
    localparam logic signed [DW-1:0] HINGE_NEG = -HINGE_ONE;
    localparam logic signed [DW-1:0] SAT_MAX   = {1'b0, {(DW-1){1'b1}}};
    localparam logic signed [DW-1:0] SAT_MIN   = {1'b1, {(DW-1){1'b0}}};

    // ------------------------------------------------------------------
    // Label FIFO
    // ------------------------------------------------------------------
    logic [VW-1:0]              fifo_mem [DEPTH];
    logic [FIFO_DEPTH_BITS-1:0] wr_ptr;
    logic [FIFO_DEPTH_BITS-1:0] rd_ptr;
    logic [FIFO_DEPTH_BITS:0]   count;
    logic [VW-1:0]              head;
    logic                       push;
    logic                       pop;
    logic                       underflow;

    // Emptiness is judged on the registered count only, so a label pushed in
    // the same cycle can never satisfy the dot arriving alongside it.
    assign b_ready   = !rst && (count < FULL_COUNT);
    assign push      = b_valid && b_ready;
    assign pop       = dot_valid && (count != '0);
    assign underflow = dot_valid && (count == '0);
    assign head      = fifo_mem[rd_ptr];
    assign b_count   = count;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + FIFO_DEPTH_BITS'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + FIFO_DEPTH_BITS'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (FIFO_DEPTH_BITS+1)'(1);
                2'b01:   count <= count - (FIFO_DEPTH_BITS+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset; it is only read when count says it is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= b_data;
        end
    end

    // ------------------------------------------------------------------
    // Config register: a change is seen by dots arriving one cycle later.
    // ------------------------------------------------------------------
    logic [4:0] cfg_shift_q;
    logic       cfg_mode_q;
    logic       cfg_round_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cfg_shift_q <= '0;
            cfg_mode_q  <= 1'b0;
            cfg_round_q <= 1'b0;
        end else begin
            cfg_shift_q <= cfg_shift;
            cfg_mode_q  <= cfg_mode;
            cfg_round_q <= cfg_round;
        end
    end

    // ------------------------------------------------------------------
    // S1: capture dot, label (zero on underflow) and config together
    // ------------------------------------------------------------------
    logic          s1_valid;
    logic [VW-1:0] s1_dot;
    logic [VW-1:0] s1_b;
    logic [4:0]    s1_shift;
    logic          s1_mode;
    logic          s1_round;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_dot   <= '0;
            s1_b     <= '0;
            s1_shift <= '0;
            s1_mode  <= 1'b0;
            s1_round <= 1'b0;
        end else begin
            s1_valid <= dot_valid;
            s1_dot   <= dot_data;
            s1_b     <= pop ? head : '0;
            s1_shift <= cfg_shift_q;
            s1_mode  <= cfg_mode_q;
            s1_round <= cfg_round_q;
        end
    end

    // ------------------------------------------------------------------
    // S2: per-bank loss
    // ------------------------------------------------------------------
    logic [VW-1:0]        s2_next;
    logic [NUM_BANKS-1:0] clamp_vec;

    for (genvar i = 0; i < NUM_BANKS; i++) begin : g_s2
        logic signed [DW-1:0] ax;
        logic signed [DW-1:0] bv;
        logic signed [DW:0]   diff;
        logic                 hi_sat;
        logic                 lo_sat;
        logic signed [DW-1:0] r;
        logic                 clamp;

        assign ax   = s1_dot[i*DW +: DW];
        assign bv   = s1_b[i*DW +: DW];
        // One extra bit holds the exact difference; the top two bits
        // disagreeing means it does not fit in DW bits.
        assign diff   = {ax[DW-1], ax} - {bv[DW-1], bv};
        assign hi_sat = !diff[DW] && diff[DW-1];
        assign lo_sat = diff[DW] && !diff[DW-1];

        // Hinge treats b >= 0 as label +1 and b < 0 as label -1.
        always_comb begin
            r     = '0;
            clamp = 1'b0;
            if (s1_mode) begin
                if (!bv[DW-1]) begin
                    r = (ax < HINGE_POS) ? HINGE_NEG : '0;
                end else begin
                    r = (ax > HINGE_NEG) ? HINGE_POS : '0;
                end
            end else if (hi_sat) begin
                r     = SAT_MAX;
                clamp = 1'b1;
            end else if (lo_sat) begin
                r     = SAT_MIN;
                clamp = 1'b1;
            end else begin
                r = diff[DW-1:0];
            end
        end

        assign s2_next[i*DW +: DW] = r;
        assign clamp_vec[i]        = clamp;
    end

    logic          s2_valid;
    logic [VW-1:0] s2_r;
    logic [4:0]    s2_shift;
    logic          s2_round;

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid <= 1'b0;
            s2_r     <= '0;
            s2_shift <= '0;
            s2_round <= 1'b0;
        end else begin
            s2_valid <= s1_valid;
            s2_r     <= s2_next;
            s2_shift <= s1_shift;
            s2_round <= s1_round;
        end
    end

    // ------------------------------------------------------------------
    // S3: step-size shift with optional round-half-up
    // ------------------------------------------------------------------
    logic [VW-1:0] s3_next;

    for (genvar i = 0; i < NUM_BANKS; i++) begin : g_s3
        logic signed [DW-1:0] r;
        logic signed [DW:0]   r_ext;
        logic signed [DW:0]   inc;
        logic signed [DW:0]   rounded;
        logic signed [DW-1:0] floor_out;
        logic signed [DW-1:0] round_out;

        assign r     = s2_r[i*DW +: DW];
        assign r_ext = {r[DW-1], r};
        // inc is meaningless when the shift is zero; that case takes floor_out.
        assign inc       = (DW+1)'(1) << (s2_shift - 5'd1);
        assign rounded   = r_ext + inc;
        assign floor_out = r >>> s2_shift;
        assign round_out = DW'(rounded >>> s2_shift);

        assign s3_next[i*DW +: DW] =
            (s2_round && (s2_shift != 5'd0)) ? round_out : floor_out;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            loss_valid <= 1'b0;
            loss_data  <= '0;
        end else begin
            loss_valid <= s2_valid;
            loss_data  <= s3_next;
        end
    end

    // ------------------------------------------------------------------
    // Sticky error flags: a set event in the same cycle beats err_clr.
    // ------------------------------------------------------------------
    logic set_sat;
    assign set_sat = s1_valid && (|clamp_vec);

    always_ff @(posedge clk) begin
        if (rst) begin
            err_underflow <= 1'b0;
            err_sat       <= 1'b0;
        end else begin
            if (underflow) begin
                err_underflow <= 1'b1;
            end else if (err_clr) begin
                err_underflow <= 1'b0;
            end
            if (set_sat) begin
                err_sat <= 1'b1;
            end else if (err_clr) begin
                err_sat <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sgd_loss_engine.sv
// tb_sgd_loss_engine
//
// Purpose:
//   Self-checking bench for sgd_loss_engine. A behavioural model (label queue,
//   queue of pending results, integer loss arithmetic) predicts every output
//   each cycle; directed scenarios add fixed-value checks, then a randomized
//   phase exercises mixed traffic and config changes.

module tb_sgd_loss_engine;

    localparam int NB    = 8;
    localparam int DW    = 32;
    localparam int FDB   = 6;
    localparam int DEPTH = 64;

    logic             clk = 1'b0;
    logic             rst;
    logic [4:0]       cfg_shift;
    logic             cfg_mode;
    logic             cfg_round;
    logic [DW*NB-1:0] b_data;
    logic             b_valid;
    logic             b_ready;
    logic [DW*NB-1:0] dot_data;
    logic             dot_valid;
    logic [DW*NB-1:0] loss_data;
    logic             loss_valid;
    logic [FDB:0]     b_count;
    logic             err_clr;
    logic             err_underflow;
    logic             err_sat;

    always #5 clk = ~clk;

    sgd_loss_engine #(
        .NUM_BANKS(NB),
        .DW(DW),
        .FIFO_DEPTH_BITS(FDB),
        .HINGE_ONE(32'h0001_0000)
    ) dut (
        .clk(clk),
        .rst(rst),
        .cfg_shift(cfg_shift),
        .cfg_mode(cfg_mode),
        .cfg_round(cfg_round),
        .b_data(b_data),
        .b_valid(b_valid),
        .b_ready(b_ready),
        .dot_data(dot_data),
        .dot_valid(dot_valid),
        .loss_data(loss_data),
        .loss_valid(loss_valid),
        .b_count(b_count),
        .err_clr(err_clr),
        .err_underflow(err_underflow),
        .err_sat(err_sat)
    );

    int assertCount = 0;
    int failCount   = 0;
    int edgeNum     = 0;

    typedef struct {
        int           outEdge;
        int           satEdge;
        logic [255:0] data;
        bit           sat;
    } pend_t;

    pend_t        pend[$];
    logic [255:0] labelQ[$];
    bit           mU = 1'b0;
    bit           mS = 1'b0;
    logic [4:0]   mShift = '0;
    bit           mMode = 1'b0;
    bit           mRound = 1'b0;

    // Reference loss for one bank, in plain 64-bit integer arithmetic.
    function automatic logic [31:0] refBank(input longint ax, input longint b, input int shift,
                                            input bit mode, input bit rnd, output bit sat);
        longint r;
        sat = 1'b0;
        if (!mode) begin
            r = ax - b;
            if (r > 64'sd2147483647) begin
                r   = 64'sd2147483647;
                sat = 1'b1;
            end else if (r < -64'sd2147483648) begin
                r   = -64'sd2147483648;
                sat = 1'b1;
            end
        end else if (b >= 0) begin
            r = (ax < 64'sd65536) ? -64'sd65536 : 64'sd0;
        end else begin
            r = (ax > -64'sd65536) ? 64'sd65536 : 64'sd0;
        end
        if (rnd && shift > 0) begin
            r = r + (64'sd1 <<< (shift - 1));
        end
        r = r >>> shift;
        return r[31:0];
    endfunction

    function automatic logic [255:0] rep(input logic [31:0] v);
        logic [255:0] x;
        for (int i = 0; i < NB; i++) begin
            x[i*32 +: 32] = v;
        end
        return x;
    endfunction

    function automatic logic [31:0] randWord();
        logic [31:0] w;
        case ($urandom_range(0, 4))
            0:       w = $urandom;
            1:       w = 32'($urandom_range(0, 4000)) - 32'd2000;
            2:       w = 32'h7FFF_FFF0 + 32'($urandom_range(0, 15));
            3:       w = 32'h8000_0000 + 32'($urandom_range(0, 15));
            default: w = 32'h0001_0000 + 32'($urandom_range(0, 8)) - 32'd4;
        endcase
        if ($urandom_range(0, 5) == 0) begin
            w = -w;
        end
        return w;
    endfunction

    function automatic logic [255:0] randVec();
        logic [255:0] x;
        for (int i = 0; i < NB; i++) begin
            x[i*32 +: 32] = randWord();
        end
        return x;
    endfunction

    task automatic checkOutput(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        assertCount++;
        assert (obs === exp)
        else begin
            failCount++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advances one clock: predicts this edge from the model, then compares.
    task automatic clockCycle();
        int           e;
        bit           expValid;
        bit           expReady;
        logic [255:0] expData;
        bit           under;
        bit           anySat;
        bit           wasEmpty;
        bit           canPush;
        bit           s;
        bit           sAny;
        logic [255:0] lbl;
        logic [255:0] res;
        pend_t        it;
        logic [4:0]   nShift;
        bit           nMode;
        bit           nRound;

        e        = edgeNum + 1;
        expValid = 1'b0;
        expData  = '0;
        under    = 1'b0;
        anySat   = 1'b0;
        res      = '0;
        if (rst) begin
            labelQ.delete();
            pend.delete();
        end else begin
            wasEmpty = (labelQ.size() == 0);
            canPush  = (labelQ.size() < DEPTH);
            if (dot_valid) begin
                lbl  = '0;
                sAny = 1'b0;
                if (wasEmpty) under = 1'b1;
                else          lbl = labelQ.pop_front();
                for (int i = 0; i < NB; i++) begin
                    res[i*32 +: 32] = refBank($signed(dot_data[i*32 +: 32]), $signed(lbl[i*32 +: 32]),
                                              int'(mShift), mMode, mRound, s);
                    sAny |= s;
                end
                it.outEdge = e + 2;
                it.satEdge = e + 1;
                it.data    = res;
                it.sat     = sAny;
                pend.push_back(it);
            end
            if (b_valid && canPush) labelQ.push_back(b_data);
            foreach (pend[k]) begin
                if (pend[k].satEdge == e && pend[k].sat) anySat = 1'b1;
            end
            if (pend.size() > 0 && pend[0].outEdge == e) begin
                expValid = 1'b1;
                expData  = pend[0].data;
                void'(pend.pop_front());
            end
        end

        if (rst) begin
            mU = 1'b0;
            mS = 1'b0;
        end else begin
            mU = under  ? 1'b1 : (err_clr ? 1'b0 : mU);
            mS = anySat ? 1'b1 : (err_clr ? 1'b0 : mS);
        end
        nShift = rst ? 5'd0 : cfg_shift;
        nMode  = rst ? 1'b0 : cfg_mode;
        nRound = rst ? 1'b0 : cfg_round;

        @(posedge clk);
        #1;
        edgeNum = e;
        mShift  = nShift;
        mMode   = nMode;
        mRound  = nRound;

        expReady = !rst && (labelQ.size() < DEPTH);
        checkOutput("loss_valid", 256'(loss_valid), 256'(expValid));
        if (expValid || rst) checkOutput("loss_data", loss_data, expData);
        checkOutput("b_count", 256'(b_count), 256'(labelQ.size()));
        checkOutput("b_ready", 256'(b_ready), 256'(expReady));
        checkOutput("err_underflow", 256'(err_underflow), 256'(mU));
        checkOutput("err_sat", 256'(err_sat), 256'(mS));
    endtask

    task automatic applyStimulus(input bit bv, input logic [255:0] bd, input bit dv,
                                 input logic [255:0] dd, input bit clr);
        b_valid   = bv;
        b_data    = bd;
        dot_valid = dv;
        dot_data  = dd;
        err_clr   = clr;
        clockCycle();
        b_valid   = 1'b0;
        dot_valid = 1'b0;
        err_clr   = 1'b0;
    endtask

    task automatic idle();
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b0);
    endtask

    task automatic setConfig(input logic [4:0] sh, input bit md, input bit rd);
        cfg_shift = sh;
        cfg_mode  = md;
        cfg_round = rd;
    endtask

    initial begin
        rst       = 1'b1;
        b_valid   = 1'b0;
        b_data    = '0;
        dot_valid = 1'b0;
        dot_data  = '0;
        err_clr   = 1'b0;
        setConfig(5'd0, 1'b0, 1'b0);

        // Reset state
        clockCycle();
        clockCycle();
        checkOutput("reset_b_count", 256'(b_count), 256'(0));
        checkOutput("reset_loss_valid", 256'(loss_valid), 256'(0));
        rst = 1'b0;
        #1;
        checkOutput("b_ready_after_reset", 256'(b_ready), 256'(1));

        // Linear: 350 - 100 = 250, valid three edges after the dot
        $display("[TB] linear mode");
        applyStimulus(1'b1, rep(32'd100), 1'b0, '0, 1'b0);
        applyStimulus(1'b0, '0, 1'b1, rep(32'd350), 1'b0);
        idle();
        checkOutput("linear_not_early", 256'(loss_valid), 256'(0));
        idle();
        checkOutput("linear_valid", 256'(loss_valid), 256'(1));
        checkOutput("linear_250", loss_data, rep(32'd250));

        // Shift and rounding
        $display("[TB] shift and rounding");
        setConfig(5'd4, 1'b0, 1'b0);
        applyStimulus(1'b1, rep(32'd17), 1'b0, '0, 1'b0);
        applyStimulus(1'b0, '0, 1'b1, rep(32'd0), 1'b0);
        idle();
        idle();
        checkOutput("shift_floor_m17", loss_data, rep(32'hFFFF_FFFE));
        setConfig(5'd4, 1'b0, 1'b1);
        applyStimulus(1'b1, rep(32'd17), 1'b0, '0, 1'b0);
        applyStimulus(1'b0, '0, 1'b1, rep(32'd0), 1'b0);
        idle();
        idle();
        checkOutput("shift_round_m17", loss_data, rep(32'hFFFF_FFFF));
        applyStimulus(1'b1, rep(32'd0), 1'b0, '0, 1'b0);
        applyStimulus(1'b0, '0, 1'b1, rep(32'd24), 1'b0);
        idle();
        idle();
        checkOutput("shift_round_p24", loss_data, rep(32'd2));

        // Saturation and sticky clear
        $display("[TB] saturation");
        setConfig(5'd0, 1'b0, 1'b0);
        applyStimulus(1'b1, rep(32'hFFFF_FFFF), 1'b0, '0, 1'b0);
        applyStimulus(1'b0, '0, 1'b1, rep(32'h7FFF_FFFF), 1'b0);
        idle();
        idle();
        checkOutput("sat_value", loss_data, rep(32'h7FFF_FFFF));
        checkOutput("sat_flag", 256'(err_sat), 256'(1));
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b1);
        checkOutput("sat_cleared", 256'(err_sat), 256'(0));

        // Hinge, back-to-back dots
        $display("[TB] hinge mode");
        setConfig(5'd0, 1'b1, 1'b0);
        applyStimulus(1'b1, rep(32'h0001_0000), 1'b0, '0, 1'b0);
        applyStimulus(1'b1, rep(32'h0001_0000), 1'b0, '0, 1'b0);
        applyStimulus(1'b1, rep(32'hFFFF_0000), 1'b0, '0, 1'b0);
        applyStimulus(1'b0, '0, 1'b1, rep(32'h0000_8000), 1'b0);
        applyStimulus(1'b0, '0, 1'b1, rep(32'h0001_8000), 1'b0);
        applyStimulus(1'b0, '0, 1'b1, rep(32'h0000_0000), 1'b0);
        checkOutput("hinge_pos_active", loss_data, rep(32'hFFFF_0000));
        idle();
        checkOutput("hinge_pos_margin", loss_data, rep(32'h0));
        idle();
        checkOutput("hinge_neg_active", loss_data, rep(32'h0001_0000));

        // FIFO full / empty boundaries
        $display("[TB] FIFO boundaries");
        setConfig(5'd2, 1'b0, 1'b0);
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(1'b1, rep(32'(i)), 1'b0, '0, 1'b0);
        end
        checkOutput("full_count", 256'(b_count), 256'(64));
        checkOutput("full_ready", 256'(b_ready), 256'(0));
        applyStimulus(1'b1, rep(32'hDEAD_BEEF), 1'b0, '0, 1'b0);
        checkOutput("full_push_ignored", 256'(b_count), 256'(64));
        applyStimulus(1'b0, '0, 1'b1, randVec(), 1'b0);
        checkOutput("ready_after_pop", 256'(b_ready), 256'(1));
        for (int i = 0; i < DEPTH - 1; i++) begin
            applyStimulus(1'b0, '0, 1'b1, randVec(), 1'b0);
        end
        applyStimulus(1'b0, '0, 1'b1, rep(32'hFFFF_FFF9), 1'b0);
        checkOutput("underflow_flag", 256'(err_underflow), 256'(1));
        idle();
        idle();
        checkOutput("underflow_value", loss_data, rep(32'hFFFF_FFFE));
        applyStimulus(1'b1, rep(32'd5), 1'b1, rep(32'd9), 1'b0);
        checkOutput("no_bypass_count", 256'(b_count), 256'(1));
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b1);
        checkOutput("underflow_cleared", 256'(err_underflow), 256'(0));

        // Reset mid-stream
        $display("[TB] reset mid-stream");
        setConfig(5'd0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, randVec(), 1'b0, '0, 1'b0);
        end
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, '0, 1'b1, randVec(), 1'b0);
        end
        rst = 1'b1;
        clockCycle();
        rst = 1'b0;
        checkOutput("midreset_count", 256'(b_count), 256'(0));
        #1;
        checkOutput("midreset_ready", 256'(b_ready), 256'(1));
        for (int i = 0; i < 5; i++) begin
            idle();
        end

        // Randomized traffic
        $display("[TB] random traffic");
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 7) == 0) begin
                setConfig(5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)));
            end
            applyStimulus(1'($urandom_range(0, 1)), randVec(),
                          1'($urandom_range(0, 2) != 0), randVec(),
                          $urandom_range(0, 15) == 0);
        end
        for (int i = 0; i < 4; i++) begin
            idle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
